// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller; no logic, no latency.
// Backpressure: not applicable.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int LCNT_W = 3;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_LOAD_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register fields in, enables/selects out.
// Backpressure: none carried here; mem_busy is just another pipeline observation.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_reg_write;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  mem_reg_write;
    logic                  wb_reg_write;
    logic                  branch_taken;
    logic                  mem_busy;

    logic                  pc_write_en;
    logic                  ifid_write_en;
    logic                  idex_write_en;
    logic                  exmem_write_en;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_mem_read, ex_reg_write, ex_rs1, ex_rs2,
               mem_rd, wb_rd, mem_reg_write, wb_reg_write,
               branch_taken, mem_busy,
        input  pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
               ifid_flush, idex_bubble, forward_a, forward_b
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_mem_read, ex_reg_write, ex_rs1, ex_rs2,
               mem_rd, wb_rd, mem_reg_write, wb_reg_write,
               branch_taken, mem_busy,
        output pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
               ifid_flush, idex_bubble, forward_a, forward_b
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// ALU operand forwarding select for one EX source register; purely combinational.
// Backpressure: none; the select follows its inputs every cycle.
module forward_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic [1:0]            fwd
);

    // EX/MEM holds the younger result, so it must win over MEM/WB.
    always_comb begin
        fwd = FWD_RF;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs))
            fwd = FWD_MEM;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs))
            fwd = FWD_WB;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall FSM, branch flush, mem freeze and forwarding; decisions same-cycle, state on clk.
// Backpressure: mem_busy freezes every pipeline register enable and all internal state.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   hz,
    output logic [CNT_W-1:0]        stall_cycles
);

    localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LOAD_LAT - 1);

    state_t            state;
    logic [LCNT_W-1:0] lcnt;
    logic              lu;
    logic              stall;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

    assign lu = (state == ST_RUN) && hz.ex_mem_read && hz.ex_reg_write &&
                (hz.ex_rd != '0) &&
                ((hz.id_rs1_used && (hz.ex_rd == hz.id_rs1)) ||
                 (hz.id_rs2_used && (hz.ex_rd == hz.id_rs2)));

    assign stall = lu || (state == ST_LOAD_STALL);

    // Priority: reset, freeze, branch flush, load stall, normal.
    always_comb begin
        hz.pc_write_en    = 1'b1;
        hz.ifid_write_en  = 1'b1;
        hz.idex_write_en  = 1'b1;
        hz.exmem_write_en = 1'b1;
        hz.ifid_flush     = 1'b0;
        hz.idex_bubble    = 1'b0;
        if (reset) begin
            hz.idex_bubble = 1'b1;
        end else if (hz.mem_busy) begin
            hz.pc_write_en    = 1'b0;
            hz.ifid_write_en  = 1'b0;
            hz.idex_write_en  = 1'b0;
            hz.exmem_write_en = 1'b0;
        end else if (hz.branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (stall) begin
            hz.pc_write_en   = 1'b0;
            hz.ifid_write_en = 1'b0;
            hz.idex_bubble   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            lcnt         <= '0;
            stall_cycles <= '0;
        end else if (!hz.mem_busy) begin
            if (hz.branch_taken) begin
                // The dependent instruction is flushed, so any pending stall is moot.
                state <= ST_RUN;
                lcnt  <= '0;
            end else if (state == ST_RUN) begin
                if (lu && (LOAD_LAT > 1)) begin
                    state <= ST_LOAD_STALL;
                    lcnt  <= LCNT_INIT;
                end
            end else begin
                if (lcnt == LCNT_W'(1))
                    state <= ST_RUN;
                lcnt <= lcnt - LCNT_W'(1);
            end
            if (!hz.branch_taken && stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .ex_rs         (hz.ex_rs1),
        .mem_rd        (hz.mem_rd),
        .mem_reg_write (hz.mem_reg_write),
        .wb_rd         (hz.wb_rd),
        .wb_reg_write  (hz.wb_reg_write),
        .fwd           (fwd_a_raw)
    );

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .ex_rs         (hz.ex_rs2),
        .mem_rd        (hz.mem_rd),
        .mem_reg_write (hz.mem_reg_write),
        .wb_rd         (hz.wb_rd),
        .wb_reg_write  (hz.wb_reg_write),
        .fwd           (fwd_b_raw)
    );

    assign hz.forward_a = reset ? FWD_RF : fwd_a_raw;
    assign hz.forward_b = reset ? FWD_RF : fwd_b_raw;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: one LOAD_LAT=1 instance and one LOAD_LAT=3, CNT_W=4 instance.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_rs1_used;
        logic       id_rs2_used;
        logic [4:0] ex_rd;
        logic       ex_mem_read;
        logic       ex_reg_write;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] mem_rd;
        logic [4:0] wb_rd;
        logic       mem_reg_write;
        logic       wb_reg_write;
        logic       branch_taken;
        logic       mem_busy;
    } in_t;

    // {pc, ifid, idex, exmem, flush, bubble}
    localparam logic [5:0] C_NORM  = 6'b111100;
    localparam logic [5:0] C_STALL = 6'b001101;
    localparam logic [5:0] C_FRZ   = 6'b000000;
    localparam logic [5:0] C_FLUSH = 6'b111111;
    localparam logic [5:0] C_RST   = 6'b111101;

    logic        clk;
    logic        reset;
    in_t         st;
    logic        sel;
    logic [31:0] cnt1;
    logic [3:0]  cnt3;
    int          n_chk;
    int          n_fail;
    logic [9:0]  exp_q[$];

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) h1 ();
    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) h3 ();

    assign {h1.id_rs1, h1.id_rs2, h1.id_rs1_used, h1.id_rs2_used, h1.ex_rd,
            h1.ex_mem_read, h1.ex_reg_write, h1.ex_rs1, h1.ex_rs2, h1.mem_rd,
            h1.wb_rd, h1.mem_reg_write, h1.wb_reg_write, h1.branch_taken,
            h1.mem_busy} = st;
    assign {h3.id_rs1, h3.id_rs2, h3.id_rs1_used, h3.id_rs2_used, h3.ex_rd,
            h3.ex_mem_read, h3.ex_reg_write, h3.ex_rs1, h3.ex_rs2, h3.mem_rd,
            h3.wb_rd, h3.mem_reg_write, h3.wb_reg_write, h3.branch_taken,
            h3.mem_busy} = st;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(32)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .hz           (h1.slave),
        .stall_cycles (cnt1)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(4)) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .hz           (h3.slave),
        .stall_cycles (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] obs();
        if (sel)
            return {h3.pc_write_en, h3.ifid_write_en, h3.idex_write_en, h3.exmem_write_en,
                    h3.ifid_flush, h3.idex_bubble, h3.forward_a, h3.forward_b};
        return {h1.pc_write_en, h1.ifid_write_en, h1.idex_write_en, h1.exmem_write_en,
                h1.ifid_flush, h1.idex_bubble, h1.forward_a, h1.forward_b};
    endfunction

    // Inputs are already applied; queue the expectation, compare at the falling edge, then step one cycle.
    task automatic cyc(input string tag, input logic [5:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
        exp_q.push_back({ctrl, fa, fb});
        @(negedge clk);
        chk_eq(tag, 32'(obs()), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
    endtask

    function automatic in_t haz();
        in_t s = '0;
        s.ex_rd        = 5'd5;
        s.ex_mem_read  = 1'b1;
        s.ex_reg_write = 1'b1;
        s.id_rs1       = 5'd5;
        s.id_rs1_used  = 1'b1;
        return s;
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        st    = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        sel    = 1'b0;
        st     = haz();
        reset  = 1'b1;

        // Reset state, with a live hazard on the inputs that must be ignored.
        #1;
        cyc("rst_ctrl1", C_RST, 2'b00, 2'b00);
        sel = 1'b1;
        cyc("rst_ctrl3", C_RST, 2'b00, 2'b00);
        chk_eq("rst_cnt1", cnt1, 32'd0);
        chk_eq("rst_cnt3", 32'(cnt3), 32'd0);
        reset = 1'b0;

        // LOAD_LAT=1: single bubble, then MEM/WB forward into the dependent.
        sel = 1'b0;
        st  = haz();
        cyc("ll1_stall", C_STALL, 2'b00, 2'b00);
        st = '0; st.id_rs1 = 5'd5; st.id_rs1_used = 1'b1; st.mem_rd = 5'd5; st.mem_reg_write = 1'b0;
        cyc("ll1_after", C_NORM, 2'b00, 2'b00);
        st = '0; st.ex_rs1 = 5'd5; st.wb_rd = 5'd5; st.wb_reg_write = 1'b1;
        cyc("ll1_fwd_wb", C_NORM, 2'b01, 2'b00);
        chk_eq("ll1_cnt", cnt1, 32'd1);

        // LOAD_LAT=3: three stall cycles, then back to RUN.
        pulse_reset();
        sel = 1'b1;
        st  = haz();
        for (int i = 0; i < 3; i++) cyc("ll3_stall", C_STALL, 2'b00, 2'b00);
        st = '0;
        cyc("ll3_run", C_NORM, 2'b00, 2'b00);
        chk_eq("ll3_cnt", 32'(cnt3), 32'd3);

        // mem_busy mid-stall stretches wall-clock time but not lcnt or the counter.
        st = haz();
        cyc("busy_s1", C_STALL, 2'b00, 2'b00);
        cyc("busy_s2", C_STALL, 2'b00, 2'b00);
        st.mem_busy = 1'b1;
        cyc("busy_f1", C_FRZ, 2'b00, 2'b00);
        cyc("busy_f2", C_FRZ, 2'b00, 2'b00);
        st.mem_busy = 1'b0;
        cyc("busy_s3", C_STALL, 2'b00, 2'b00);
        st = '0;
        cyc("busy_run", C_NORM, 2'b00, 2'b00);
        chk_eq("busy_cnt", 32'(cnt3), 32'd6);

        // Qualification: x0 destination and unused rs2 never stall.
        st = haz(); st.ex_rd = 5'd0; st.id_rs1 = 5'd0;
        cyc("x0_nostall", C_NORM, 2'b00, 2'b00);
        st = haz(); st.id_rs1 = 5'd9; st.id_rs2 = 5'd5; st.id_rs2_used = 1'b0;
        cyc("rs2_unused", C_NORM, 2'b00, 2'b00);
        st.id_rs2_used = 1'b1;
        cyc("rs2_used", C_STALL, 2'b00, 2'b00);
        st = '0;
        cyc("rs2_s2", C_STALL, 2'b00, 2'b00);
        cyc("rs2_s3", C_STALL, 2'b00, 2'b00);
        cyc("rs2_run", C_NORM, 2'b00, 2'b00);
        chk_eq("qual_cnt", 32'(cnt3), 32'd9);

        // Branch beats a same-cycle hazard and aborts an in-progress stall.
        st = haz(); st.branch_taken = 1'b1;
        cyc("br_same", C_FLUSH, 2'b00, 2'b00);
        st = '0;
        cyc("br_same_run", C_NORM, 2'b00, 2'b00);
        chk_eq("br_same_cnt", 32'(cnt3), 32'd9);
        st = haz();
        cyc("br_mid_s1", C_STALL, 2'b00, 2'b00);
        st.branch_taken = 1'b1;
        cyc("br_mid", C_FLUSH, 2'b00, 2'b00);
        st = '0;
        cyc("br_mid_run", C_NORM, 2'b00, 2'b00);
        chk_eq("br_mid_cnt", 32'(cnt3), 32'd10);

        // Forwarding priority and x0 exclusion; selects ignore freeze/flush.
        st = '0; st.ex_rs2 = 5'd7; st.mem_rd = 5'd7; st.wb_rd = 5'd7;
        st.mem_reg_write = 1'b1; st.wb_reg_write = 1'b1;
        cyc("fwd_b_mem", C_NORM, 2'b00, 2'b10);
        st.mem_reg_write = 1'b0;
        cyc("fwd_b_wb", C_NORM, 2'b00, 2'b01);
        st.mem_reg_write = 1'b1; st.mem_rd = 5'd0;
        cyc("fwd_b_x0", C_NORM, 2'b00, 2'b01);
        st = '0; st.ex_rs1 = 5'd12; st.mem_rd = 5'd12; st.mem_reg_write = 1'b1; st.mem_busy = 1'b1;
        cyc("fwd_a_busy", C_FRZ, 2'b10, 2'b00);
        st.mem_busy = 1'b0; st.branch_taken = 1'b1; st.ex_rs2 = 5'd12;
        cyc("fwd_ab_br", C_FLUSH, 2'b10, 2'b10);

        // Reset asserted mid-stall: immediate reset outputs, no residual stall afterwards.
        st = haz();
        cyc("rmid_s1", C_STALL, 2'b00, 2'b00);
        reset = 1'b1;
        st.ex_rs1 = 5'd5; st.wb_rd = 5'd5; st.wb_reg_write = 1'b1;
        cyc("rmid_rst", C_RST, 2'b00, 2'b00);
        chk_eq("rmid_cnt", 32'(cnt3), 32'd0);
        reset = 1'b0;
        st = '0;
        cyc("rmid_run", C_NORM, 2'b00, 2'b00);
        cyc("rmid_run2", C_NORM, 2'b00, 2'b00);
        chk_eq("rmid_cnt2", 32'(cnt3), 32'd0);

        // 18 stall cycles into a 4-bit counter: must hold at 15.
        for (int k = 0; k < 6; k++) begin
            st = haz();
            for (int j = 0; j < 3; j++) cyc("sat_stall", C_STALL, 2'b00, 2'b00);
            st = '0;
            cyc("sat_run", C_NORM, 2'b00, 2'b00);
            if (k == 3) chk_eq("sat_mid", 32'(cnt3), 32'd12);
        end
        chk_eq("sat_hold", 32'(cnt3), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline, sitting beside the ID stage and driving pipeline-register enables, bubble/flush controls and ALU operand forwarding selects. Successor to the single-cycle load-use detector. Adds:
- a configurable multi-cycle load-use stall FSM
- x0 and operand-usage qualification
- taken-branch flush and data-memory wait freeze
- EX/MEM and MEM/WB forwarding
- a saturating stall-cycle counter

## Interface
- REG_ADDR_W, 5, register index width
- LOAD_LAT, 1, bubbles inserted per load-use hazard; legal 1..7
- CNT_W, 32, width of stall statistics counter
- clk  in  1  pipeline clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of instruction in ID
- id_rs1_used, id_rs2_used  in  1  instruction in ID actually reads rs1/rs2
- ex_rd  in  REG_ADDR_W  destination of instruction in EX
- ex_mem_read, ex_reg_write  in  1  EX instruction is a load / writes rd
- ex_rs1, ex_rs2  in  REG_ADDR_W  sources of instruction in EX (forwarding)
- mem_rd, wb_rd  in  REG_ADDR_W  destinations in MEM, WB
- mem_reg_write, wb_reg_write  in  1  MEM/WB instruction writes rd
- branch_taken  in  1  branch/jump in EX resolved taken
- mem_busy  in  1  data memory not ready this cycle
- pc_write_en, ifid_write_en, idex_write_en, exmem_write_en  out  1  register enables
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  zero ID/EX control fields (control mux select)
- forward_a, forward_b  out  2  ALU operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
- stall_cycles  out  CNT_W  saturating count of load-use stall cycles

## Operation
- FSM states: RUN, LOAD_STALL. A down-counter `lcnt` (3 bits) counts remaining stall cycles.
- Load-use hazard `lu` (evaluated only in RUN) requires all of:
  - ex_mem_read & ex_reg_write
  - ex_rd != 0
  - (id_rs1_used & ex_rd == id_rs1) | (id_rs2_used & ex_rd == id_rs2)
- Stall action:
  - pc_write_en = 0, ifid_write_en = 0, idex_bubble = 1
  - idex_write_en = 1, exmem_write_en = 1
- RUN & lu:
  - Stall this cycle.
  - If LOAD_LAT > 1: next state LOAD_STALL, lcnt = LOAD_LAT-1.
  - Otherwise remain in RUN.
- LOAD_STALL:
  - Stall every cycle; lcnt decrements.
  - When lcnt == 1, next state RUN.
  - Total stall cycles per hazard = LOAD_LAT.
- Priority, highest first:
  - mem_busy: freeze. All four write enables 0, no flush, no bubble; FSM state, lcnt and counter hold.
  - branch_taken: ifid_flush = 1, idex_bubble = 1, all enables 1. FSM forced to RUN, lcnt = 0. Stall is abandoned because the dependent instruction is flushed.
  - Load stall.
  - Normal: all enables 1, flush 0, bubble 0.
- Forwarding (per operand, shown for A using ex_rs1; B identical with ex_rs2):
  - 10 if mem_reg_write & mem_rd != 0 & mem_rd == ex_rs1
  - else 01 if wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1
  - else 00
  - EX/MEM wins over MEM/WB when both match.
  - Forwarding selects are unaffected by mem_busy and branch_taken.
- stall_cycles:
  - Increments by 1 on every clock edge in which the load-stall action was driven (not freeze, not branch).
  - Saturates at all-ones.

## Timing
- All hazard outputs are combinational from inputs plus registered state. No latency in the detection cycle.
- FSM and counter update on the rising clk edge.
- reset asserted (async, immediate):
  - state RUN, lcnt 0, stall_cycles 0
  - outputs forced to all enables 1, ifid_flush 0, idex_bubble 1, forward_a/b 00
- reset released: normal evaluation from the next input change. First state update on the first rising edge after deassertion.
- Reset mid-stall aborts the stall. The first post-reset cycle is RUN.
- mem_busy during LOAD_STALL extends the wall-clock stall without consuming lcnt.
- branch_taken and lu in the same cycle: branch wins; the counter does not increment.
- ex_rd == 0 load never stalls. Stores/branches with idN_used = 0 never stall on that operand.

## Structure
- Shared package hazard_pkg holds:
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
  - FSM state encoding ST_RUN, ST_LOAD_STALL
- One sub-module: forward_sel, combinational, instantiated twice (operand A, operand B). Takes ex_rs, mem/wb rd and reg_write; returns 2-bit select.
- FSM, lcnt, priority mux and stall counter live in the top.

## Test plan
- LOAD_LAT=1: load ex_rd=5, id_rs1=5 used:
  - exactly 1 cycle with pc_write_en=0, idex_bubble=1
  - then forward_a=01 when dependent is in EX
  - stall_cycles=1
- LOAD_LAT=3: same hazard:
  - 3 consecutive stall cycles, FSM returns to RUN
  - stall_cycles=3
  - repeat with mem_busy=1 for 2 cycles mid-stall: 5 total frozen/stalled cycles, stall_cycles still 3
- Load ex_rd=0 matching id_rs1=0, or id_rs2 match with id_rs2_used=0: no stall, counter unchanged.
- branch_taken=1 in same cycle as lu (LOAD_LAT=3), and in the 2nd LOAD_STALL cycle:
  - ifid_flush=1, idex_bubble=1, enables 1
  - FSM RUN next cycle, no further stalls
- mem_rd=wb_rd=ex_rs2=7, both writing: forward_b=10. Clearing mem_reg_write gives 01. Setting mem_rd=0 with mem_reg_write=1 gives 01.
- Assert reset during LOAD_STALL:
  - outputs immediately at reset values, stall_cycles=0
  - after release, no residual stall
  - force stall_cycles near saturation (CNT_W=4): it holds at 15
